// File: rtl/csel_resolver.sv
// csel_resolver: serial carry-select resolver for conditional-sum slice pairs.
// Each accepted pair carries a 2-bit sum and carry-out for carry-in 0 and 1.
// The running carry picks one of the two. Slice 0 (the LSBs) is resolved first.
// Latency: out_valid rises one cycle after the last slice transfer.
// Backpressure: in_ready is high only in COLLECT. The result is held in DONE until out_ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, cin          begin a new resolution with the given initial carry
//   in_valid/in_ready   slice-pair handshake
//   sum0/cout0          slice result assuming carry-in 0
//   sum1/cout1          slice result assuming carry-in 1
//   out_valid/out_ready result handshake
//   result, cout        resolved sum and final carry-out
//   busy                high whenever the FSM is not IDLE
//   err                 (ERR_CHK_EN only) sticky pair-consistency error
//
// Optional feature macro: ERR_CHK_EN adds the err port and the per-pair consistency check.
module csel_resolver #(
  parameter int N_SLICES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cin,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            sum1,
  input  logic                  cout1,
  input  logic [1:0]            sum0,
  input  logic                  cout0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*N_SLICES-1:0] result,
  output logic                  cout,
  output logic                  busy
`ifdef ERR_CHK_EN
  ,
  output logic                  err
`endif
);

  localparam int IDX_W = $clog2(N_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;

  // The running carry decides which precomputed slice result is the real one.
  logic [1:0] sel_s;
  logic       sel_c;
  assign sel_s = carry ? sum1  : sum0;
  assign sel_c = carry ? cout1 : cout0;

`ifdef ERR_CHK_EN
  // A consistent pair satisfies {cout1,sum1} == {cout0,sum0} + 1.
  // The sum is taken at 4 bits, so a wrap from 7 to 0 is never treated as a match.
  logic pair_bad;
  assign pair_bad = ({1'b0, cout1, sum1} != ({1'b0, cout0, sum0} + 4'd1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ERR_CHK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COLLECT;
            carry    <= cin;
            idx      <= '0;
            result   <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
`ifdef ERR_CHK_EN
            err      <= 1'b0;
`endif
          end
        end

        COLLECT: begin
          // in_ready is always high here, so in_valid alone marks a transfer.
          if (in_valid) begin
            result[{idx, 1'b0} +: 2] <= sel_s;
            carry                    <= sel_c;
`ifdef ERR_CHK_EN
            if (pair_bad) err <= 1'b1;
`endif
            if (idx == LAST_IDX) begin
              state     <= DONE;
              cout      <= sel_c;
              idx       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              // Back-to-back: skip IDLE and go straight to collecting.
              state    <= COLLECT;
              carry    <= cin;
              idx      <= '0;
              result   <= '0;
              in_ready <= 1'b1;
`ifdef ERR_CHK_EN
              err      <= 1'b0;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          idx       <= '0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csel_resolver.sv
// Directed testbench for csel_resolver (N_SLICES=4).
// Operand bytes are split into 2-bit slices, and the bench builds both conditional-sum results for each pair.
// Expected results are hand-computed constants.
module tb_csel_resolver;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cin;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sum1;
  logic       cout1;
  logic [1:0] sum0;
  logic       cout0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       cout;
  logic       busy;
`ifdef ERR_CHK_EN
  logic       err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  csel_resolver #(.N_SLICES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum1      (sum1),
    .cout1     (cout1),
    .sum0      (sum0),
    .cout0     (cout0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
`ifdef ERR_CHK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one raw pair and wait (bounded) for it to be accepted.
  task automatic xfer_raw(input logic [1:0] s0, input logic c0,
                          input logic [1:0] s1, input logic c1);
    int n;
    sum0 = s0; cout0 = c0; sum1 = s1; cout1 = c1;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL xfer_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic xfer(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] t0, t1;
    t0 = {1'b0, a} + {1'b0, b};
    t1 = {1'b0, a} + {1'b0, b} + 3'd1;
    xfer_raw(t0[1:0], t0[2], t1[1:0], t1[2]);
  endtask

  task automatic start_op(input logic c);
    start = 1'b1; cin = c;
    @(posedge clk); #1;
    start = 1'b0; cin = 1'b0;
  endtask

  task automatic send_all(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < N; i++) xfer(a[2*i +: 2], b[2*i +: 2]);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sum0 = 2'b00; cout0 = 1'b0; sum1 = 2'b00; cout1 = 1'b0;
    #3;
    vectors++;
    if ({in_ready, out_valid, busy, cout} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: {in_ready,out_valid,busy,cout}=%b required 0000", {in_ready, out_valid, busy, cout});
    end
    vectors++;
    if (result !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_result: got %h required 00", result);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    start_op(1'b0);   // first edge after reset release
    vectors++;
    if ({busy, in_ready, out_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL basic_start: {busy,in_ready,out_valid}=%b required 110", {busy, in_ready, out_valid});
    end
    for (int i = 0; i < N - 1; i++) xfer(2'((8'h5A >> (2*i)) & 8'h3), 2'((8'h3C >> (2*i)) & 8'h3));
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early_valid: out_valid=%b required 0", out_valid);
    end
    xfer(2'((8'h5A >> 6) & 8'h3), 2'((8'h3C >> 6) & 8'h3));
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_latency: out_valid=%b in_ready=%b required 1,0", out_valid, in_ready);
    end
    vectors++;
    if (result !== 8'h96 || cout !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got %h/%b required 96/0", result, cout);
    end
    accept();
    vectors++;
    if ({busy, out_valid} !== 2'b00 || result !== 8'h96) begin
      miscompares++;
      $display("FAIL basic_idle_hold: busy=%b out_valid=%b result=%h required 0,0,96", busy, out_valid, result);
    end
  endtask

  task automatic test_carry();
    start_op(1'b1);
    send_all(8'h7F, 8'h00);
    vectors++;
    if (result !== 8'h80 || cout !== 1'b0) begin
      miscompares++;
      $display("FAIL carry_7f_cin1: got %h/%b required 80/0", result, cout);
    end
    accept();
    start_op(1'b0);
    send_all(8'hFF, 8'h01);
    vectors++;
    if (result !== 8'h00 || cout !== 1'b1) begin
      miscompares++;
      $display("FAIL carry_ff_01: got %h/%b required 00/1", result, cout);
    end
    accept();
    vectors++;
    if (cout !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL carry_idle_cout: cout=%b out_valid=%b required 1,0", cout, out_valid);
    end
  endtask

  task automatic test_async_reset();
    start_op(1'b0);
    xfer(2'b10, 2'b00);
    xfer(2'b10, 2'b11);
    vectors++;
    if (result !== 8'h06) begin
      miscompares++;
      $display("FAIL areset_partial: got %h required 06", result);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, in_ready, out_valid, cout} !== 4'b0000 || result !== 8'h00) begin
      miscompares++;
      $display("FAIL areset_async: flags=%b result=%h required 0000/00", {busy, in_ready, out_valid, cout}, result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy, out_valid} !== 2'b00 || result !== 8'h00) begin
      miscompares++;
      $display("FAIL areset_release: busy=%b out_valid=%b result=%h required 0,0,00", busy, out_valid, result);
    end
    start_op(1'b0);
    send_all(8'h12, 8'h34);
    vectors++;
    if (result !== 8'h46 || cout !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_fresh: got %h/%b valid=%b required 46/0/1", result, cout, out_valid);
    end
    accept();
  endtask

  task automatic test_gaps();
    logic [7:0] a, b;
    a = 8'h5A; b = 8'h3C;
    start_op(1'b0);
    for (int i = 0; i < N; i++) begin
      xfer(a[2*i +: 2], b[2*i +: 2]);
      if (i < N - 1) begin
        // A start seen during COLLECT must be ignored.
        start = 1'b1; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0; cin = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL gap_hold_%0d: in_ready=%b out_valid=%b required 1,0", i, in_ready, out_valid);
        end
      end
    end
    // Hold off the consumer while pushing junk pairs and start.
    in_valid = 1'b1; sum0 = 2'b11; cout0 = 1'b1; sum1 = 2'b11; cout1 = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || result !== 8'h96 || cout !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL gap_stall_%0d: valid=%b result=%h cout=%b in_ready=%b required 1,96,0,0", k, out_valid, result, cout, in_ready);
      end
    end
    in_valid = 1'b0; start = 1'b0;
    accept();
    vectors++;
    if ({busy, out_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL gap_release: busy=%b out_valid=%b required 0,0", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    start_op(1'b0);
    send_all(8'hFF, 8'h01);
    out_ready = 1'b1; start = 1'b1; cin = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0; cin = 1'b0;
    vectors++;
    if ({busy, in_ready, out_valid} !== 3'b110 || result !== 8'h00) begin
      miscompares++;
      $display("FAIL b2b_restart: flags=%b result=%h required 110/00", {busy, in_ready, out_valid}, result);
    end
    send_all(8'h01, 8'h01);
    vectors++;
    if (result !== 8'h03 || cout !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_result: got %h/%b valid=%b required 03/0/1", result, cout, out_valid);
    end
    accept();
  endtask

  task automatic test_err();
`ifdef ERR_CHK_EN
    start_op(1'b0);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_initial: err=%b required 0", err);
    end
    xfer_raw(2'b01, 1'b0, 2'b01, 1'b0);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set: err=%b required 1", err);
    end
    xfer(2'b00, 2'b00);
    xfer(2'b00, 2'b00);
    xfer(2'b00, 2'b00);
    vectors++;
    if (err !== 1'b1 || result !== 8'h01) begin
      miscompares++;
      $display("FAIL err_sticky: err=%b result=%h required 1/01", err, result);
    end
    accept();
    start_op(1'b0);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: err=%b required 0", err);
    end
    send_all(8'h21, 8'h12);
    vectors++;
    if (err !== 1'b0 || result !== 8'h33) begin
      miscompares++;
      $display("FAIL err_clean_op: err=%b result=%h required 0/33", err, result);
    end
    accept();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_async_reset();
    test_gaps();
    test_back_to_back();
    test_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csel_resolver.md
CSEL_RESOLVER -- requirements
Module: csel_resolver

Interface
REQ-001 Parameter: N_SLICES, default 4, number of 2-bit slices per operand; legal range 2..8.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  begin a new resolution; sampled only when accepting a new operation.
REQ-005 Port: cin  input  1  initial carry-in, sampled with start.
REQ-006 Port: in_valid  input  1  slice pair presented.
REQ-007 Port: in_ready  output  1  block accepts a slice pair this cycle.
REQ-008 Port: sum1 / cout1  input  2 / 1  slice sum and carry assuming carry-in 1.
REQ-009 Port: sum0 / cout0  input  2 / 1  slice sum and carry assuming carry-in 0.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer takes result.
REQ-012 Port: result  output  2*N_SLICES  resolved sum.
REQ-013 Port: cout  output  1  final carry-out.
REQ-014 Port: busy  output  1  high in any state except IDLE.
REQ-015 Port (ERR_CHK_EN only): err  output  1  sticky pair-consistency error for current operation.

Function
REQ-016 Block is the consumer of conditional-sum slice pairs: it resolves the carry chain serially, slice 0 (LSBs) first.
REQ-017 FSM states IDLE, COLLECT, DONE; reset state IDLE.
REQ-018 IDLE: in_ready=0, out_valid=0; start=1 -> COLLECT, carry<=cin, idx<=0, result<=0.
REQ-019 COLLECT: in_ready=1; transfer occurs when in_valid & in_ready.
REQ-020 On transfer: selected {c,s} = carry ? {cout1,sum1} : {cout0,sum0}; result[2*idx+1:2*idx]<=s; carry<=c; idx<=idx+1.
REQ-021 Transfer with idx==N_SLICES-1 -> DONE; cout<=selected c; out_valid asserts the following cycle (1-cycle latency from last transfer).
REQ-022 in_valid=0 in COLLECT: state, idx, carry held; no timeout.
REQ-023 DONE: in_ready=0; out_valid=1; result, cout held stable until out_ready=1.
REQ-024 DONE with out_ready=1 and start=0 -> IDLE.
REQ-025 DONE with out_ready=1 and start=1 -> COLLECT directly (back-to-back), cin sampled, result cleared next cycle.
REQ-026 start while in COLLECT, or in DONE without out_ready, is ignored.
REQ-027 result and cout retain last values in IDLE until the next start.

Reset
REQ-028 rst=1 forces immediately, independent of clk: state=IDLE, idx=0, carry=0, result=0, cout=0, in_ready=0, out_valid=0, busy=0, err=0.
REQ-029 rst asserted mid-COLLECT or in DONE abandons the operation; no partial result is presented after release.
REQ-030 First start is honoured on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro ERR_CHK_EN: when defined, each transfer checks {cout1,sum1} == {cout0,sum0}+1 (3-bit, no wrap); a mismatch sets err, held until next start or rst; result computed normally.
REQ-032 Without ERR_CHK_EN: no err port, no check logic; all other behaviour identical.

Verification
REQ-033 N_SLICES=4, cin=0, pairs from A=0x5A, B=0x3C -> result=0x96, cout=0, out_valid one cycle after 4th transfer.
REQ-034 A=0xFF, B=0x01, cin=0 -> result=0x00, cout=1; A=0x7F, B=0x00, cin=1 -> result=0x80, cout=0.
REQ-035 in_valid gaps of 3 cycles between slices, then out_ready low 5 cycles -> result/out_valid stable, no extra transfers, same result as gap-free run.
REQ-036 rst pulsed after 2 of 4 transfers -> all outputs 0 asynchronously; fresh start with A=0x12, B=0x34 -> result=0x46.
REQ-037 DONE with out_ready=1 and start=1, cin=1 -> COLLECT next cycle, next A=0x01, B=0x01 -> result=0x03.
REQ-038 ERR_CHK_EN: slice pair sum0=01, cout0=0, sum1=01, cout1=0 -> err=1 after transfer, cleared by next start.
